pb_conditioner: RTL and testbench
=================================

PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 3, giving the consecutive hz100 cycles of a stable changed level before a button's debounced state follows it (legal 1..15).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50, giving the hold cycles before the first auto-repeat strobe (used only with PB_REPEAT_EN).
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 10, giving the cycles between later auto-repeat strobes (used only with PB_REPEAT_EN).
REQ-004 hz100  input  1  sole clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pb  input  21  raw, asynchronous pushbutton levels, 1 = pressed.
REQ-007 keyvalid  output  1  1 while any debounced button is pressed.
REQ-008 keycode  output  5  index of the highest-numbered debounced pressed button; 0 when keyvalid=0.
REQ-009 strobe  output  1  one-cycle pulse per accepted key event.
REQ-010 last_key  output  5  keycode captured on the most recent strobe.
REQ-011 run  output  1  run/stop level for downstream enable logic.

Function
REQ-012 Each pb bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Per bit, a counter SHALL increment on each edge where the synchronized value differs from the debounced state, SHALL clear on any edge where they match, and the debounced state SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE, with the counter then clearing.
REQ-014 A pb level stable from before edge 1 SHALL be visible on keyvalid/keycode after edge DEBOUNCE+2; a pulse shorter than DEBOUNCE synchronized cycles SHALL produce no change.
REQ-015 keyvalid and keycode SHALL be combinational from the debounced state only; the highest index wins when several buttons are pressed.
REQ-016 strobe SHALL be 1 exactly in the first cycle in which keyvalid=1 after a cycle with keyvalid=0; additional buttons pressed while keyvalid stays 1 SHALL NOT strobe.
REQ-017 On an edge with strobe=1, last_key SHALL load keycode.
REQ-018 On an edge with an initial (non-repeat) strobe: keycode=19 SHALL clear run to 0; otherwise keycode=1 SHALL toggle run; all other codes SHALL leave run unchanged.
REQ-019 With pb[1] and pb[19] pressed together, keycode=19 SHALL apply and run SHALL clear.
REQ-020 Release, meaning keyvalid falling after debouncing, SHALL produce no strobe and leave last_key and run unchanged.

Reset
REQ-021 While reset=1: synchronizers, debounce counters, debounced states, run, last_key and the repeat counter SHALL be 0, giving keyvalid=0, keycode=0 and strobe=0.
REQ-022 A reset mid-press SHALL discard the press; a button still held after release of reset SHALL be re-debounced and SHALL produce a new strobe after DEBOUNCE+2 edges.

Configuration
REQ-023 With PB_REPEAT_EN defined, while keyvalid stays 1, strobe SHALL also pulse on the REPEAT_DELAY-th held cycle after the initial strobe and then every REPEAT_PERIOD cycles; repeat strobes SHALL update last_key but SHALL NOT affect run.
REQ-024 Any keyvalid=0 cycle SHALL clear the repeat counter.
REQ-025 Without PB_REPEAT_EN, strobe SHALL occur only per REQ-016, and the repeat counter and parameters SHALL generate no logic.

Structure
REQ-026 Package pb_pkg SHALL hold NBTN=21, RUN_KEY=5'd1, CLR_KEY=5'd19 and typedef keycode_t (5-bit logic).
REQ-027 Sub-module pb_debounce (one bit: synchronizer, counter, debounced state) SHALL be instantiated NBTN times by a generate loop; encoding, strobe, run and repeat logic SHALL reside in pb_conditioner.

Verification
REQ-028 A bench SHALL cover this case: pb[1] set for 10 cycles, DEBOUNCE=3 -> keyvalid=1 and keycode=1 after edge 5, strobe high one cycle, run 0->1, last_key=1.
REQ-029 A bench SHALL cover this case: pb[7] high for 2 cycles only -> keyvalid, strobe and run never change.
REQ-030 A bench SHALL cover this case: run=1, then pb[1] and pb[19] set on the same cycle -> keycode=19, one strobe, run=0, last_key=19.
REQ-031 A bench SHALL cover this case: pb[3] held, then pb[12] added -> keycode 3->12 with no second strobe; both released -> keyvalid=0 with no strobe.
REQ-032 A bench SHALL cover this case: reset pulsed while pb[1] is held with run=1 -> all outputs 0; after reset release, strobe at edge 5 and run=1.
REQ-033 A bench SHALL cover this case: with PB_REPEAT_EN, pb[4] held for 80 cycles -> strobes at 0, 50, 60 and 70 cycles after the initial strobe, last_key=4 and run unchanged.

Source files
------------

// File: rtl/pb_pkg.sv
// pb_pkg: shared constants and types for the pushbutton conditioner.
//   NBTN    - number of raw pushbutton inputs
//   RUN_KEY - keycode that toggles run on an initial strobe
//   CLR_KEY - keycode that clears run on an initial strobe (wins over RUN_KEY)
//   keycode_t - 5-bit button index
package pb_pkg;

  localparam int unsigned NBTN = 21;

  typedef logic [4:0] keycode_t;

  localparam keycode_t RUN_KEY = 5'd1;
  localparam keycode_t CLR_KEY = 5'd19;

endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: one-bit pushbutton conditioner.
// A two-flop synchronizer feeds a mismatch counter; the debounced state follows the
// synchronized level once it has differed for DEBOUNCE consecutive edges.
// Ports:
//   hz100 - clock, rising edge
//   reset - asynchronous, active-high
//   pb    - raw asynchronous button level (1 = pressed)
//   state - debounced level
module pb_debounce #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic hz100,
  input  logic reset,
  input  logic pb,
  output logic state
);

  logic       sync1_q, sync2_q;
  logic       state_q;
  logic [3:0] count_q;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      count_q <= 4'd0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
      if (sync2_q != state_q) begin
        // The edge that would bring the count to DEBOUNCE commits the new level.
        if (count_q == 4'(DEBOUNCE - 1)) begin
          state_q <= sync2_q;
          count_q <= 4'd0;
        end else begin
          count_q <= count_q + 4'd1;
        end
      end else begin
        count_q <= 4'd0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: debounces NBTN pushbuttons, encodes the highest pressed button,
// emits one strobe per new key press and maintains a run/stop level.
// Optional feature: define PB_REPEAT_EN to add auto-repeat strobes while a key is held
// (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
// Ports:
//   hz100    - clock, rising edge
//   reset    - asynchronous, active-high
//   pb       - raw button levels, 1 = pressed
//   keyvalid - any debounced button pressed
//   keycode  - highest-numbered debounced pressed button, 0 when none
//   strobe   - one-cycle pulse per accepted key event
//   last_key - keycode captured on the most recent strobe
//   run      - run/stop level
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic [NBTN-1:0] pb,
  output logic            keyvalid,
  output keycode_t        keycode,
  output logic            strobe,
  output keycode_t        last_key,
  output logic            run
);

  logic [NBTN-1:0] deb;
  logic            kv_prev_q;
  logic            run_q;
  keycode_t        last_key_q;
  logic            strobe_init;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    pb_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .hz100(hz100),
      .reset(reset),
      .pb   (pb[g]),
      .state(deb[g])
    );
  end

  // Later iterations overwrite earlier ones, so the highest pressed index wins.
  always_comb begin
    keycode = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (deb[i]) keycode = keycode_t'(i);
    end
  end

  assign keyvalid    = |deb;
  assign strobe_init = keyvalid & ~kv_prev_q;

`ifdef PB_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_target;
  logic            rep_phase_q, rep_phase_d;
  logic            rep_strobe;

  // Phase 0 waits REPEAT_DELAY cycles from the initial strobe; phase 1 repeats every
  // REPEAT_PERIOD cycles. The counter holds the cycles elapsed within the current phase.
  assign rep_target = rep_phase_q ? RepW'(REPEAT_PERIOD) : RepW'(REPEAT_DELAY);
  assign rep_strobe = keyvalid & (rep_cnt_q == rep_target);

  always_comb begin
    rep_cnt_d   = rep_cnt_q + RepW'(1);
    rep_phase_d = rep_phase_q;
    if (!keyvalid) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (rep_strobe) begin
      rep_cnt_d   = RepW'(1);
      rep_phase_d = 1'b1;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign strobe = strobe_init | rep_strobe;
`else
  // Repeat timing parameters are inert in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};

  assign strobe = strobe_init;
`endif

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      kv_prev_q  <= 1'b0;
      run_q      <= 1'b0;
      last_key_q <= '0;
    end else begin
      kv_prev_q <= keyvalid;
      if (strobe) last_key_q <= keycode;
      // Only the initial strobe of a press drives run; CLR_KEY takes priority.
      if (strobe_init) begin
        if (keycode == CLR_KEY) begin
          run_q <= 1'b0;
        end else if (keycode == RUN_KEY) begin
          run_q <= ~run_q;
        end
      end
    end
  end

  assign run      = run_q;
  assign last_key = last_key_q;

endmodule

// File: tb/tb_pb_conditioner.sv
module tb_pb_conditioner;

  localparam int D  = 3;
  localparam int RD = 50;
  localparam int RP = 10;

  logic        hz100 = 1'b0;
  logic        reset;
  logic [20:0] pb;
  logic        keyvalid;
  logic [4:0]  keycode;
  logic        strobe;
  logic [4:0]  last_key;
  logic        run;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nstrobe  = 0;

  // Reference model state
  logic [20:0] m_s1, m_s2, m_deb;
  int          m_cnt[21];
  bit          m_kvp;
  bit          m_run;
  logic [4:0]  m_last;
  int          m_t;

  always #5 hz100 = ~hz100;

  pb_conditioner #(
    .DEBOUNCE     (D),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .hz100   (hz100),
    .reset   (reset),
    .pb      (pb),
    .keyvalid(keyvalid),
    .keycode (keycode),
    .strobe  (strobe),
    .last_key(last_key),
    .run     (run)
  );

  function automatic logic [4:0] top_idx(input logic [20:0] v);
    logic [4:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int i = 20; i >= 0; i--) begin
      if (v[i] && !found) begin
        r = 5'(i);
        found = 1;
      end
    end
    return r;
  endfunction

  function automatic bit m_strobe();
    bit kv, init, rep;
    kv   = |m_deb;
    init = kv && !m_kvp;
    rep  = 0;
`ifdef PB_REPEAT_EN
    rep = kv && !init && (m_t >= RD) && (((m_t - RD) % RP) == 0);
`endif
    return init || rep;
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 21; i++) m_cnt[i] = 0;
    m_kvp = 0; m_run = 0; m_last = '0; m_t = 0;
  endtask

  task automatic model_edge();
    bit kv, init, st;
    logic [4:0] kc;
    if (reset) begin
      model_clear();
      return;
    end
    kv   = |m_deb;
    kc   = top_idx(m_deb);
    init = kv && !m_kvp;
    st   = m_strobe();
    if (st) m_last = kc;
    if (init) begin
      if (kc == 5'd19) m_run = 0;
      else if (kc == 5'd1) m_run = !m_run;
    end
    m_kvp = kv;
    m_t   = kv ? m_t + 1 : 0;
    for (int i = 0; i < 21; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        if (m_cnt[i] + 1 == D) begin
          m_deb[i] = m_s2[i];
          m_cnt[i] = 0;
        end else begin
          m_cnt[i]++;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = pb;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("keyvalid", 32'(keyvalid), 32'(|m_deb));
    check("keycode", 32'(keycode), 32'(top_idx(m_deb)));
    check("strobe", 32'(strobe), 32'(m_strobe()));
    check("run", 32'(run), 32'(m_run));
    check("last_key", 32'(last_key), 32'(m_last));
  endtask

  task automatic tick();
    @(posedge hz100);
    model_edge();
    #2;
    cyc++;
    compare_all();
    if (strobe === 1'b1) nstrobe++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s0;
    int offs[$];
    int first;

    // Reset
    reset = 1'b1;
    pb    = '0;
    model_clear();
    #1;
    compare_all();
    ticks(2);
    reset = 1'b0;
    ticks(3);

    // pb[1] pressed for 10 cycles: press accepted after edge 5, run toggles on
    s0 = nstrobe;
    pb = 21'(1) << 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) check("s1_kv_early", 32'(keyvalid), 32'd0);
      if (k == 5) begin
        check("s1_kv", 32'(keyvalid), 32'd1);
        check("s1_kc", 32'(keycode), 32'd1);
        check("s1_strobe", 32'(strobe), 32'd1);
        check("s1_run_pre", 32'(run), 32'd0);
      end
      if (k == 6) begin
        check("s1_strobe_off", 32'(strobe), 32'd0);
        check("s1_run", 32'(run), 32'd1);
        check("s1_last", 32'(last_key), 32'd1);
      end
    end
    pb = '0;
    ticks(10);
    check("s1_release_kv", 32'(keyvalid), 32'd0);
    check("s1_release_run", 32'(run), 32'd1);
    check("s1_nstrobe", 32'(nstrobe - s0), 32'd1);

    // Glitch on pb[7] shorter than the debounce window
    s0 = nstrobe;
    pb = 21'(1) << 7;
    ticks(2);
    pb = '0;
    ticks(10);
    check("s2_nstrobe", 32'(nstrobe - s0), 32'd0);
    check("s2_run", 32'(run), 32'd1);
    check("s2_last", 32'(last_key), 32'd1);

    // pb[1] and pb[19] together: clear key wins
    s0 = nstrobe;
    pb = (21'(1) << 1) | (21'(1) << 19);
    ticks(5);
    check("s3_kc", 32'(keycode), 32'd19);
    check("s3_strobe", 32'(strobe), 32'd1);
    tick();
    check("s3_run", 32'(run), 32'd0);
    check("s3_last", 32'(last_key), 32'd19);
    ticks(4);
    pb = '0;
    ticks(8);
    check("s3_nstrobe", 32'(nstrobe - s0), 32'd1);

    // pb[3] held, pb[12] added, then both released
    s0 = nstrobe;
    pb = 21'(1) << 3;
    ticks(8);
    check("s4_kc3", 32'(keycode), 32'd3);
    pb = (21'(1) << 3) | (21'(1) << 12);
    ticks(5);
    check("s4_kc12", 32'(keycode), 32'd12);
    check("s4_nstrobe_held", 32'(nstrobe - s0), 32'd1);
    pb = '0;
    ticks(8);
    check("s4_kv_off", 32'(keyvalid), 32'd0);
    check("s4_nstrobe", 32'(nstrobe - s0), 32'd1);
    check("s4_last", 32'(last_key), 32'd3);
    check("s4_run", 32'(run), 32'd0);

    // Reset while pb[1] is held with run=1
    pb = 21'(1) << 1;
    ticks(8);
    check("s5_run_pre", 32'(run), 32'd1);
    reset = 1'b1;
    #1;
    model_clear();
    check("s5_rst_kv", 32'(keyvalid), 32'd0);
    check("s5_rst_strobe", 32'(strobe), 32'd0);
    check("s5_rst_run", 32'(run), 32'd0);
    check("s5_rst_last", 32'(last_key), 32'd0);
    ticks(2);
    reset = 1'b0;
    s0 = nstrobe;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 4) check("s5_kv_early", 32'(keyvalid), 32'd0);
      if (k == 5) check("s5_strobe", 32'(strobe), 32'd1);
      if (k == 6) check("s5_run", 32'(run), 32'd1);
    end
    pb = '0;
    ticks(8);
    check("s5_nstrobe", 32'(nstrobe - s0), 32'd1);

    // pb[4] held for 80 cycles
    s0 = nstrobe;
    first = -1;
    pb = 21'(1) << 4;
    for (int k = 0; k < 95; k++) begin
      if (k == 80) pb = '0;
      tick();
      if (strobe === 1'b1) begin
        if (first < 0) first = cyc;
        offs.push_back(cyc - first);
      end
    end
`ifdef PB_REPEAT_EN
    check("s6_nstrobe", 32'(nstrobe - s0), 32'd4);
    if (offs.size() == 4) begin
      check("s6_off1", 32'(offs[1]), 32'd50);
      check("s6_off2", 32'(offs[2]), 32'd60);
      check("s6_off3", 32'(offs[3]), 32'd70);
    end
`else
    check("s6_nstrobe", 32'(nstrobe - s0), 32'd1);
`endif
    check("s6_last", 32'(last_key), 32'd4);
    check("s6_run", 32'(run), 32'd1);

    // Randomized bursts checked against the model
    for (int b = 0; b < 60; b++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 3) pb = '0;
      else if (r < 7) pb = 21'(1) << $urandom_range(0, 20);
      else if (r < 8) pb = (21'(1) << 1) | (21'(1) << 19);
      else pb = (21'(1) << $urandom_range(0, 20)) | (21'(1) << $urandom_range(0, 20));
      ticks(int'($urandom_range(1, 12)));
    end
    pb = '0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
